// File: rtl/matrix_result_tx_if.sv
// Handshake bundle between the result transmitter, its output FIFO and the UART.
interface matrix_result_tx_if;
   logic       start;
   logic [3:0] result_len;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       pop_FIFO_out;
   logic       uart_tx_busy;
   logic       UART_send;
   logic [7:0] UART_send_data;
   logic       busy;
   logic       done;

   modport master (
      output start, result_len, fifo_empty, fifo_data, uart_tx_busy,
      input  pop_FIFO_out, UART_send, UART_send_data, busy, done
   );

   modport slave (
      input  start, result_len, fifo_empty, fifo_data, uart_tx_busy,
      output pop_FIFO_out, UART_send, UART_send_data, busy, done
   );
endinterface

// File: rtl/matrix_result_tx.sv
// Sends a result frame: HEADER, N, CMD, N FIFO bytes, [checksum], TAIL over a UART.
// Optional feature: define RESULT_CHECKSUM_EN to append the XOR of N and all data bytes.
module matrix_result_tx #(
   parameter int unsigned MAX_N       = 8,
   parameter logic [7:0]  HEADER_BYTE = 8'hFE,
   parameter logic [7:0]  CMD_RESULT  = 8'h04,
   parameter logic [7:0]  TAIL_BYTE   = 8'hEF
) (
   input logic              clk,
   input logic              reset,
   matrix_result_tx_if.slave bus
);

   localparam int unsigned LEN_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_N);

   typedef enum logic [3:0] {
      IDLE, HDR, LEN, CMD, POP, LOAD, DATA, CSUM, TAIL, ACK, DONE
   } state_t;

`ifdef RESULT_CHECKSUM_EN
   localparam state_t AFTER_DATA = CSUM;
`else
   localparam state_t AFTER_DATA = TAIL;
`endif

   state_t             state_q, state_d;
   state_t             from_q, from_d;
   logic [LEN_W-1:0]   n_q, n_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               seen_q, seen_d;
   logic               pop_q, pop_d;
   logic               send_q, send_d;
   logic [BYTE_W-1:0]  data_q, data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef RESULT_CHECKSUM_EN
   logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

   logic [LEN_W-1:0]   len_clamp_c;
   logic [LEN_W-1:0]   cnt_inc_c;
   logic               ack_done_c;
   logic [BYTE_W-1:0]  tx_byte_c;

   assign len_clamp_c = (bus.result_len > MAX_LEN) ? MAX_LEN : bus.result_len;
   assign cnt_inc_c   = cnt_q + LEN_W'(1);
   assign ack_done_c  = seen_q && !bus.uart_tx_busy;

   // Byte presented by whichever header/trailer state is active.
   always_comb begin
      tx_byte_c = data_q;
      case (state_q)
         HDR:     tx_byte_c = HEADER_BYTE;
         LEN:     tx_byte_c = BYTE_W'(n_q);
         CMD:     tx_byte_c = CMD_RESULT;
         TAIL:    tx_byte_c = TAIL_BYTE;
`ifdef RESULT_CHECKSUM_EN
         CSUM:    tx_byte_c = csum_q;
`endif
         default: tx_byte_c = data_q;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; ACK resumes based on which byte state launched it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start) state_d = HDR;
         HDR, LEN, CMD, DATA, CSUM, TAIL:
            if (!bus.uart_tx_busy) state_d = ACK;
         POP:  if (!bus.fifo_empty) state_d = LOAD;
         LOAD: if (!pop_q) state_d = DATA;
         ACK: begin
            if (ack_done_c) begin
               case (from_q)
                  HDR:     state_d = LEN;
                  LEN:     state_d = CMD;
                  CMD:     state_d = (n_q == '0) ? AFTER_DATA : POP;
                  DATA:    state_d = (cnt_inc_c < n_q) ? POP : AFTER_DATA;
                  CSUM:    state_d = TAIL;
                  default: state_d = DONE;
               endcase
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      from_d = from_q;
      n_d    = n_q;
      cnt_d  = cnt_q;
      seen_d = seen_q;
      pop_d  = 1'b0;
      send_d = 1'b0;
      data_d = data_q;
      busy_d = busy_q;
      done_d = 1'b0;
`ifdef RESULT_CHECKSUM_EN
      csum_d = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               n_d    = len_clamp_c;
               cnt_d  = '0;
               busy_d = 1'b1;
`ifdef RESULT_CHECKSUM_EN
               csum_d = BYTE_W'(len_clamp_c);
`endif
            end
         end
         HDR, LEN, CMD, DATA, CSUM, TAIL: begin
            if (!bus.uart_tx_busy) begin
               send_d = 1'b1;
               data_d = tx_byte_c;
               from_d = state_q;
               seen_d = 1'b0;
            end
         end
         POP: if (!bus.fifo_empty) pop_d = 1'b1;
         LOAD: begin
            // First LOAD cycle carries the pop; the FIFO data is valid on the next one.
            if (!pop_q) begin
               data_d = bus.fifo_data;
`ifdef RESULT_CHECKSUM_EN
               csum_d = csum_q ^ bus.fifo_data;
`endif
            end
         end
         ACK: begin
            if (bus.uart_tx_busy) seen_d = 1'b1;
            if (ack_done_c) begin
               if (from_q == DATA) cnt_d = cnt_inc_c;
               if (from_q == TAIL) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         from_q <= IDLE;
         n_q    <= '0;
         cnt_q  <= '0;
         seen_q <= 1'b0;
         pop_q  <= 1'b0;
         send_q <= 1'b0;
         data_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
         csum_q <= '0;
`endif
      end else begin
         from_q <= from_d;
         n_q    <= n_d;
         cnt_q  <= cnt_d;
         seen_q <= seen_d;
         pop_q  <= pop_d;
         send_q <= send_d;
         data_q <= data_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef RESULT_CHECKSUM_EN
         csum_q <= csum_d;
`endif
      end
   end

   assign bus.pop_FIFO_out   = pop_q;
   assign bus.UART_send      = send_q;
   assign bus.UART_send_data = data_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;

endmodule
